// File: rtl/line_burst_adaptor_pkg.sv
// Shared types and sizing for the line burst adaptor.
// Optional statistics counters are enabled with LINE_ADAPTOR_STATS_EN.
package line_adaptor_types;

    localparam int S_OFFSET   = 5;
    localparam int S_LINE     = 8 * (2 ** S_OFFSET);
    localparam int S_BURST    = 64;
    localparam int N_BEATS    = S_LINE / S_BURST;
    localparam int BEAT_IDX_W = $clog2(N_BEATS);

    localparam logic [31:0] LINE_ADDR_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/line_burst_adaptor_control.sv
// Burst sequencer: accepts a line request in IDLE, counts beats on pmem_resp, pulses resp.
// Latency: n_beats+1 cycles from request to resp with no stalls; stalls hold the beat index.
// Backpressure: pmem_resp low freezes the counter; requests are ignored outside IDLE.
module line_adaptor_control
    import line_adaptor_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic                  pmem_resp,
    output adaptor_state_t        state,
    output logic [BEAT_IDX_W-1:0] shift_sel,
    output logic                  load_beat,
    output logic                  resp,
    output logic                  accept_rd,
    output logic                  accept_wr
);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(N_BEATS - 1);

    adaptor_state_t        state_q, state_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic                  skip_q, skip_d;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        skip_d    = 1'b0;
        load_beat = 1'b0;
        resp      = 1'b0;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        case (state_q)
            IDLE: begin
                // The requester still holds its request in the first IDLE cycle after resp.
                if (!skip_q) begin
                    if (line_read) begin
                        accept_rd = 1'b1;
                        state_d   = RD_BURST;
                    end else if (line_write) begin
                        accept_wr = 1'b1;
                        state_d   = WR_BURST;
                    end
                end
            end
            RD_BURST, WR_BURST: begin
                if (pmem_resp) begin
                    load_beat = (state_q == RD_BURST);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                resp    = 1'b1;
                beat_d  = '0;
                skip_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            skip_q  <= skip_d;
        end
    end

    assign state     = state_q;
    assign shift_sel = beat_q;

endmodule

// File: rtl/line_burst_adaptor.sv
// Line-to-burst adaptor: 256-bit line requests become 4 x 64-bit memory beats (stats: LINE_ADAPTOR_STATS_EN).
// Latency: line_resp n_beats+1 cycles after the request with zero-stall memory.
// Backpressure: each beat waits for pmem_resp; the requester holds its request until line_resp.
module line_burst_adaptor
    import line_adaptor_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        line_addr,
    input  logic               line_read,
    input  logic               line_write,
    input  logic [S_LINE-1:0]  line_wdata,
    output logic [S_LINE-1:0]  line_rdata,
    output logic               line_resp,
    output logic [31:0]        pmem_address,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [S_BURST-1:0] pmem_burst_o,
    input  logic [S_BURST-1:0] pmem_burst_i,
    input  logic               pmem_resp
`ifdef LINE_ADAPTOR_STATS_EN
   ,output logic [31:0]        stat_reads,
    output logic [31:0]        stat_writes,
    output logic [31:0]        stat_stall_cycles
`endif
);

    adaptor_state_t        state;
    logic [BEAT_IDX_W-1:0] shift_sel;
    logic                  load_beat, resp, accept_rd, accept_wr;

    logic [31:0]       addr_q, addr_d;
    logic [S_LINE-1:0] wdata_q, wdata_d;
    logic [S_LINE-1:0] rdata_q, rdata_d;

    line_adaptor_control u_control (
        .clk        (clk),
        .rst        (rst),
        .line_read  (line_read),
        .line_write (line_write),
        .pmem_resp  (pmem_resp),
        .state      (state),
        .shift_sel  (shift_sel),
        .load_beat  (load_beat),
        .resp       (resp),
        .accept_rd  (accept_rd),
        .accept_wr  (accept_wr)
    );

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept_rd || accept_wr) begin
            addr_d = line_addr & LINE_ADDR_MASK;
        end
        if (accept_wr) begin
            wdata_d = line_wdata;
        end
        if (load_beat) begin
            rdata_d[S_BURST*shift_sel +: S_BURST] = pmem_burst_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign line_rdata   = rdata_q;
    assign line_resp    = resp;
    assign pmem_address = addr_q;
    assign pmem_read    = (state == RD_BURST);
    assign pmem_write   = (state == WR_BURST);
    assign pmem_burst_o = wdata_q[S_BURST*shift_sel +: S_BURST];

`ifdef LINE_ADAPTOR_STATS_EN
    logic [31:0] reads_q, reads_d, writes_q, writes_d, stalls_q, stalls_d;
    logic        last_rd_q, last_rd_d;

    always_comb begin
        reads_d   = reads_q;
        writes_d  = writes_q;
        stalls_d  = stalls_q;
        last_rd_d = last_rd_q;
        if (accept_rd) begin
            last_rd_d = 1'b1;
        end else if (accept_wr) begin
            last_rd_d = 1'b0;
        end
        if (resp) begin
            if (last_rd_q && reads_q != '1) begin
                reads_d = reads_q + 32'd1;
            end else if (!last_rd_q && writes_q != '1) begin
                writes_d = writes_q + 32'd1;
            end
        end
        if ((pmem_read || pmem_write) && !pmem_resp && stalls_q != '1) begin
            stalls_d = stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reads_q   <= '0;
            writes_q  <= '0;
            stalls_q  <= '0;
            last_rd_q <= 1'b0;
        end else begin
            reads_q   <= reads_d;
            writes_q  <= writes_d;
            stalls_q  <= stalls_d;
            last_rd_q <= last_rd_d;
        end
    end

    assign stat_reads        = reads_q;
    assign stat_writes       = writes_q;
    assign stat_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Bench for line_burst_adaptor: directed line requests, a scripted memory, and a
// scoreboard of expected line responses checked by an independent monitor.
module tb_line_burst_adaptor;
    import line_adaptor_types::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        line_addr;
    logic               line_read, line_write;
    logic [S_LINE-1:0]  line_wdata, line_rdata;
    logic               line_resp;
    logic [31:0]        pmem_address;
    logic               pmem_read, pmem_write;
    logic [S_BURST-1:0] pmem_burst_o, pmem_burst_i;
    logic               pmem_resp;
`ifdef LINE_ADAPTOR_STATS_EN
    logic [31:0]        stat_reads, stat_writes, stat_stall_cycles;
`endif

    line_burst_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .line_addr    (line_addr),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_burst_o (pmem_burst_o),
        .pmem_burst_i (pmem_burst_i),
        .pmem_resp    (pmem_resp)
`ifdef LINE_ADAPTOR_STATS_EN
       ,.stat_reads        (stat_reads),
        .stat_writes       (stat_writes),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [S_LINE-1:0] rdata;
        int                cyc;
    } exp_t;
    exp_t sbq[$];

    logic [S_LINE-1:0] last_rd = '0;
    int exp_reads = 0, exp_writes = 0, exp_stalls = 0;

    function automatic void chk(string name, logic [S_LINE-1:0] act, logic [S_LINE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Response monitor: every line_resp must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && line_resp === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: line_resp=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sbq.pop_front();
                chk("resp_rdata", line_rdata, e.rdata);
                chk("resp_cycle", S_LINE'(cyc), S_LINE'(e.cyc));
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [S_LINE-1:0] line,
                           input int stall, input bit also_wr, input int abort_at);
        logic [31:0] exp_addr;
        int c0;
        exp_addr = addr & 32'hFFFF_FFE0;
        @(posedge clk); #1;
        line_read = 1'b1;
        line_addr = addr;
        if (also_wr) begin
            line_write = 1'b1;
            line_wdata = {4{64'hDEAD_BEEF_0BAD_F00D}};
            $display("note: illegal input, line_read and line_write both high");
        end
        c0 = cyc;
        if (abort_at < 0) sbq.push_back('{line, c0 + 1 + N_BEATS * (1 + stall)});
        @(posedge clk); #1;
        line_addr = ~addr;
        for (int k = 0; k < N_BEATS; k++) begin
            for (int s = 0; s < stall; s++) begin
                pmem_resp = 1'b0;
                @(negedge clk);
                chk("rd_stall_read", S_LINE'(pmem_read), S_LINE'(1'b1));
                exp_stalls++;
                @(posedge clk); #1;
            end
            pmem_resp    = 1'b1;
            pmem_burst_i = line[64*k +: 64];
            if (k == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_pmem_read", S_LINE'(pmem_read), '0);
                chk("abort_line_resp", S_LINE'(line_resp), '0);
                chk("abort_rdata", line_rdata, '0);
                @(posedge clk); #1;
                rst        = 1'b0;
                line_read  = 1'b0;
                line_write = 1'b0;
                pmem_resp  = 1'b0;
                last_rd    = '0;
                exp_reads  = 0;
                exp_writes = 0;
                exp_stalls = 0;
                return;
            end
            @(negedge clk);
            chk("rd_pmem_read", S_LINE'(pmem_read), S_LINE'(1'b1));
            chk("rd_pmem_write", S_LINE'(pmem_write), '0);
            chk("rd_address", S_LINE'(pmem_address), S_LINE'(exp_addr));
            @(posedge clk); #1;
        end
        pmem_resp = 1'b0;
        exp_reads++;
        last_rd = line;
        @(posedge clk); #1;
        line_read  = 1'b0;
        line_write = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [S_LINE-1:0] line, input int stall);
        logic [31:0] exp_addr;
        int c0;
        exp_addr = addr & 32'hFFFF_FFE0;
        @(posedge clk); #1;
        line_write = 1'b1;
        line_addr  = addr;
        line_wdata = line;
        c0 = cyc;
        sbq.push_back('{last_rd, c0 + 1 + N_BEATS * (1 + stall)});
        @(posedge clk); #1;
        line_wdata = ~line;
        line_addr  = ~addr;
        for (int k = 0; k < N_BEATS; k++) begin
            for (int s = 0; s < stall; s++) begin
                pmem_resp = 1'b0;
                @(negedge clk);
                chk("wr_stall_beat", S_LINE'(pmem_burst_o), S_LINE'(line[64*k +: 64]));
                chk("wr_stall_write", S_LINE'(pmem_write), S_LINE'(1'b1));
                exp_stalls++;
                @(posedge clk); #1;
            end
            pmem_resp = 1'b1;
            @(negedge clk);
            chk("wr_beat", S_LINE'(pmem_burst_o), S_LINE'(line[64*k +: 64]));
            chk("wr_pmem_write", S_LINE'(pmem_write), S_LINE'(1'b1));
            chk("wr_pmem_read", S_LINE'(pmem_read), '0);
            chk("wr_address", S_LINE'(pmem_address), S_LINE'(exp_addr));
            @(posedge clk); #1;
        end
        pmem_resp = 1'b0;
        exp_writes++;
        @(posedge clk); #1;
        line_write = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        line_addr    = '0;
        line_read    = 1'b0;
        line_write   = 1'b0;
        line_wdata   = '0;
        pmem_burst_i = '0;
        pmem_resp    = 1'b0;
        #12;
        chk("rst_rdata", line_rdata, '0);
        chk("rst_resp", S_LINE'(line_resp), '0);
        chk("rst_address", S_LINE'(pmem_address), '0);
        chk("rst_read", S_LINE'(pmem_read), '0);
        chk("rst_write", S_LINE'(pmem_write), '0);
        chk("rst_burst_o", S_LINE'(pmem_burst_o), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-stall read: resp lands exactly n_beats+1 cycles after the request.
        do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 1'b0, -1);
        // Write with two stall cycles before each beat; line_rdata must be untouched.
        do_write(32'h8000_0040, {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
                                 64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000}, 2);
        // Read and write together: only a read burst.
        do_read(32'h0000_2010, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0}, 0, 1'b1, -1);
        // Reset lands on beat 2 of a read.
        do_read(32'h0000_3000, {4{64'h7777_8888_9999_AAAA}}, 1, 1'b0, 2);
        do_read(32'h0000_4008, {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                                64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001}, 0, 1'b0, -1);
        // Back-to-back read then write at different addresses.
        do_read(32'h0000_5000, {64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
                                64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4}, 1, 1'b0, -1);
        do_write(32'hC000_009F, {64'h1357_9BDF_2468_ACE0, 64'h0FED_CBA9_8765_4321,
                                 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00}, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", S_LINE'(sbq.size()), '0);
`ifdef LINE_ADAPTOR_STATS_EN
        chk("stat_reads", S_LINE'(stat_reads), S_LINE'(exp_reads));
        chk("stat_writes", S_LINE'(stat_writes), S_LINE'(exp_writes));
        chk("stat_stalls", S_LINE'(stat_stall_cycles), S_LINE'(exp_stalls));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
